// File: rtl/l1_bus_pkg.sv
// rtl/l1_bus_pkg.sv - shared types and lane/alignment helpers for the L1 bus unit
package l1_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SGL,
      S_WL_PREP,
      S_WL_BEAT,
      S_RL_BEAT,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [3:0] SIZE_1B = 4'b0001;
   localparam logic [3:0] SIZE_2B = 4'b0010;
   localparam logic [3:0] SIZE_4B = 4'b0100;
   localparam logic [3:0] SIZE_8B = 4'b1000;

   function automatic logic [7:0] lane_mask(input logic [3:0] size, input logic [2:0] off);
      logic [7:0] m;
      case (size)
         SIZE_1B: m = 8'h01;
         SIZE_2B: m = 8'h03;
         SIZE_4B: m = 8'h0F;
         SIZE_8B: m = 8'hFF;
         default: m = 8'h00;
      endcase
      return m << off;
   endfunction

   // Non-one-hot sizes are rejected here, so they never reach the bus.
   function automatic logic size_aligned(input logic [3:0] size, input logic [2:0] off);
      case (size)
         SIZE_1B: return 1'b1;
         SIZE_2B: return off[0] == 1'b0;
         SIZE_4B: return off[1:0] == 2'b00;
         SIZE_8B: return off == 3'b000;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] replicate(input logic [3:0] size, input logic [63:0] d);
      case (size)
         SIZE_1B: return {8{d[7:0]}};
         SIZE_2B: return {4{d[15:0]}};
         SIZE_4B: return {2{d[31:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/l1_bus_timeout.sv
// rtl/l1_bus_timeout.sv - per-beat watchdog; expired flags the last waiting cycle
module l1_bus_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 2);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && TIMEOUT != 0) begin
         count <= count + 1'b1;
      end
   end

   // Fires in the cycle whose closing edge would bring the count to TIMEOUT.
   assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/l1_bus_unit.sv
// rtl/l1_bus_unit.sv - L1 cache bus unit: single and line requests onto a 64-bit Wishbone-classic master
module l1_bus_unit #(
   parameter int LINE_BYTES = 64,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write_through_req,
   input  logic        write_line_req,
   input  logic        read_req,
   input  logic        read_line_req,
   input  logic [3:0]  size,
   input  logic [63:0] pa,
   input  logic [63:0] wt_data,
   output logic [63:0] line_data,
   output logic [10:0] addr_count,
   output logic        line_write,
   output logic        cache_entry_write,
   output logic        trans_rdy,
   output logic        bus_error,
   output logic        m_cyc,
   output logic        m_stb,
   output logic        m_we,
   output logic [63:0] m_adr,
   output logic [7:0]  m_sel,
   output logic [63:0] m_dat_o,
   input  logic [63:0] m_dat_i,
   input  logic        m_ack,
   input  logic        m_err
);

   import l1_bus_pkg::*;

   localparam int LB = $clog2(LINE_BYTES);
   localparam int BW = LB - 3;

   state_t        state;
   logic [BW-1:0] beat;
   logic [BW-1:0] beat_nxt;
   logic          is_read;
   logic          hold;
   logic          sgl_req;
   logic          tmo_en;
   logic          tmo_clr;
   logic          expired;
   logic          fail;

   function automatic logic [63:0] beat_adr(input logic [63:0] a, input logic [BW-1:0] b);
      return {a[63:LB], b, 3'b000};
   endfunction

   function automatic logic [10:0] beat_off(input logic [BW-1:0] b);
      return 11'({b, 3'b000});
   endfunction

   assign beat_nxt = beat + 1'b1;
   // A read loses to a pending line write; a write-through beats everything.
   assign sgl_req  = write_through_req || (read_req && !write_line_req);
   assign tmo_en   = m_stb && !m_ack && !m_err;
   assign tmo_clr  = !tmo_en;
   assign fail     = m_err || expired;

   l1_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clr),
      .enable  (tmo_en),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         beat              <= '0;
         is_read           <= 1'b0;
         hold              <= 1'b0;
         line_data         <= '0;
         addr_count        <= '0;
         line_write        <= 1'b0;
         cache_entry_write <= 1'b0;
         trans_rdy         <= 1'b0;
         bus_error         <= 1'b0;
         m_cyc             <= 1'b0;
         m_stb             <= 1'b0;
         m_we              <= 1'b0;
         m_adr             <= '0;
         m_sel             <= '0;
         m_dat_o           <= '0;
      end else begin
         line_write        <= 1'b0;
         cache_entry_write <= 1'b0;
         trans_rdy         <= 1'b0;
         bus_error         <= 1'b0;
         case (state)
            S_IDLE: begin
               hold <= 1'b0;
               if (!hold) begin
                  if (sgl_req) begin
                     is_read <= !write_through_req;
                     if (!size_aligned(size, pa[2:0])) begin
                        state     <= S_ERR;
                        bus_error <= 1'b1;
                     end else begin
                        state   <= S_SGL;
                        m_cyc   <= 1'b1;
                        m_stb   <= 1'b1;
                        m_we    <= write_through_req;
                        m_adr   <= {pa[63:3], 3'b000};
                        m_sel   <= lane_mask(size, pa[2:0]);
                        m_dat_o <= replicate(size, wt_data);
                     end
                  end else if (write_line_req) begin
                     state      <= S_WL_PREP;
                     m_cyc      <= 1'b1;
                     m_we       <= 1'b1;
                     m_sel      <= 8'hFF;
                     beat       <= '0;
                     addr_count <= '0;
                  end else if (read_line_req) begin
                     state <= S_RL_BEAT;
                     m_cyc <= 1'b1;
                     m_stb <= 1'b1;
                     m_we  <= 1'b0;
                     m_sel <= 8'hFF;
                     beat  <= '0;
                     m_adr <= beat_adr(pa, {BW{1'b0}});
                  end
               end
            end
            S_SGL: begin
               if (fail) begin
                  state     <= S_ERR;
                  bus_error <= 1'b1;
                  m_cyc     <= 1'b0;
                  m_stb     <= 1'b0;
                  m_we      <= 1'b0;
               end else if (m_ack) begin
                  state     <= S_DONE;
                  trans_rdy <= 1'b1;
                  m_cyc     <= 1'b0;
                  m_stb     <= 1'b0;
                  m_we      <= 1'b0;
                  if (is_read) line_data <= m_dat_i;
               end
            end
            S_WL_PREP: begin
               state   <= S_WL_BEAT;
               m_stb   <= 1'b1;
               m_adr   <= beat_adr(pa, beat);
               m_dat_o <= wt_data;
            end
            S_WL_BEAT: begin
               if (fail) begin
                  state     <= S_ERR;
                  bus_error <= 1'b1;
                  m_cyc     <= 1'b0;
                  m_stb     <= 1'b0;
                  m_we      <= 1'b0;
               end else if (m_ack) begin
                  m_stb <= 1'b0;
                  if (&beat) begin
                     state     <= S_DONE;
                     trans_rdy <= 1'b1;
                     m_cyc     <= 1'b0;
                     m_we      <= 1'b0;
                  end else begin
                     state      <= S_WL_PREP;
                     beat       <= beat_nxt;
                     addr_count <= beat_off(beat_nxt);
                  end
               end
            end
            S_RL_BEAT: begin
               // Strobe low here means the last beat's line_write is on the outputs.
               if (!m_stb) begin
                  state             <= S_DONE;
                  trans_rdy         <= 1'b1;
                  cache_entry_write <= 1'b1;
                  m_cyc             <= 1'b0;
               end else if (fail) begin
                  state     <= S_ERR;
                  bus_error <= 1'b1;
                  m_cyc     <= 1'b0;
                  m_stb     <= 1'b0;
               end else if (m_ack) begin
                  line_data  <= m_dat_i;
                  addr_count <= beat_off(beat);
                  line_write <= 1'b1;
                  if (&beat) begin
                     m_stb <= 1'b0;
                  end else begin
                     beat  <= beat_nxt;
                     m_adr <= beat_adr(pa, beat_nxt);
                  end
               end
            end
            S_DONE, S_ERR: begin
               state <= S_IDLE;
               hold  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_bus_unit.sv
// tb/tb_l1_bus_unit.sv - directed self-checking bench for l1_bus_unit
module tb_l1_bus_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        write_through_req = 1'b0;
   logic        write_line_req = 1'b0;
   logic        read_req = 1'b0;
   logic        read_line_req = 1'b0;
   logic [3:0]  size = 4'b0000;
   logic [63:0] pa = '0;
   logic [63:0] wt_data = '0;
   logic [63:0] line_data;
   logic [10:0] addr_count;
   logic        line_write;
   logic        cache_entry_write;
   logic        trans_rdy;
   logic        bus_error;
   logic        m_cyc;
   logic        m_stb;
   logic        m_we;
   logic [63:0] m_adr;
   logic [7:0]  m_sel;
   logic [63:0] m_dat_o;
   logic [63:0] m_dat_i = '0;
   logic        m_ack = 1'b0;
   logic        m_err = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   l1_bus_unit #(.LINE_BYTES(64), .TIMEOUT(255)) dut (
      .clk               (clk),
      .rst               (rst),
      .write_through_req (write_through_req),
      .write_line_req    (write_line_req),
      .read_req          (read_req),
      .read_line_req     (read_line_req),
      .size              (size),
      .pa                (pa),
      .wt_data           (wt_data),
      .line_data         (line_data),
      .addr_count        (addr_count),
      .line_write        (line_write),
      .cache_entry_write (cache_entry_write),
      .trans_rdy         (trans_rdy),
      .bus_error         (bus_error),
      .m_cyc             (m_cyc),
      .m_stb             (m_stb),
      .m_we              (m_we),
      .m_adr             (m_adr),
      .m_sel             (m_sel),
      .m_dat_o           (m_dat_o),
      .m_dat_i           (m_dat_i),
      .m_ack             (m_ack),
      .m_err             (m_err)
   );

   function automatic logic [63:0] rpat(input logic [63:0] a);
      return {a[31:0] ^ 32'h5A5A_0F0F, a[31:0]};
   endfunction

   function automatic logic [63:0] wpat(input logic [10:0] off);
      return {53'h1F00D, off};
   endfunction

   task automatic clear_inputs();
      write_through_req = 1'b0;
      write_line_req    = 1'b0;
      read_req          = 1'b0;
      read_line_req     = 1'b0;
      m_ack             = 1'b0;
      m_err             = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({m_cyc, m_stb, m_we} !== 3'b000) begin
         errors++; $display("FAIL reset_bus: cyc/stb/we=%b expected 000", {m_cyc, m_stb, m_we});
      end
      checks++;
      if (line_data !== 64'h0 || addr_count !== 11'h0) begin
         errors++; $display("FAIL reset_data: line_data=%h addr_count=%0d expected 0 0", line_data, addr_count);
      end
      checks++;
      if ({line_write, cache_entry_write, trans_rdy, bus_error} !== 4'b0000) begin
         errors++; $display("FAIL reset_pulses: %b expected 0000", {line_write, cache_entry_write, trans_rdy, bus_error});
      end
      checks++;
      if (m_adr !== 64'h0 || m_sel !== 8'h0 || m_dat_o !== 64'h0) begin
         errors++; $display("FAIL reset_adr: adr=%h sel=%h dat=%h expected 0", m_adr, m_sel, m_dat_o);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_read_single();
      read_req = 1'b1; pa = 64'h1004; size = 4'b0100;
      @(negedge clk);
      checks++;
      if ({m_cyc, m_stb, m_we} !== 3'b110) begin
         errors++; $display("FAIL rd_ctl: cyc/stb/we=%b expected 110", {m_cyc, m_stb, m_we});
      end
      checks++;
      if (m_adr !== 64'h1000 || m_sel !== 8'hF0) begin
         errors++; $display("FAIL rd_adr: adr=%h sel=%h expected 1000 f0", m_adr, m_sel);
      end
      @(negedge clk);
      m_ack = 1'b1; m_dat_i = 64'hAABBCCDD_11223344;
      @(negedge clk);
      m_ack = 1'b0;
      checks++;
      if (line_data !== 64'hAABBCCDD_11223344 || trans_rdy !== 1'b1 || m_cyc !== 1'b0) begin
         errors++; $display("FAIL rd_done: line_data=%h trans_rdy=%b m_cyc=%b expected aabbccdd11223344 1 0",
                            line_data, trans_rdy, m_cyc);
      end
      @(negedge clk);
      checks++;
      if (trans_rdy !== 1'b0 || cache_entry_write !== 1'b0) begin
         errors++; $display("FAIL rd_pulse: trans_rdy=%b cew=%b expected 0 0", trans_rdy, cache_entry_write);
      end
      @(negedge clk);
      checks++;
      if (m_cyc !== 1'b0) begin
         errors++; $display("FAIL rd_rearb_gap: m_cyc=%b expected 0", m_cyc);
      end
      clear_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_misaligned();
      write_through_req = 1'b1; pa = 64'h2003; size = 4'b0010;
      @(negedge clk);
      checks++;
      if (bus_error !== 1'b1 || m_cyc !== 1'b0 || trans_rdy !== 1'b0) begin
         errors++; $display("FAIL wt_misalign: bus_error=%b m_cyc=%b trans_rdy=%b expected 1 0 0", bus_error, m_cyc, trans_rdy);
      end
      @(negedge clk);
      checks++;
      if (bus_error !== 1'b0 || m_cyc !== 1'b0) begin
         errors++; $display("FAIL wt_misalign_pulse: bus_error=%b m_cyc=%b expected 0 0", bus_error, m_cyc);
      end
      clear_inputs();
      repeat (2) @(negedge clk);
      read_req = 1'b1; pa = 64'h0; size = 4'b0011;
      @(negedge clk);
      checks++;
      if (bus_error !== 1'b1 || m_cyc !== 1'b0) begin
         errors++; $display("FAIL rd_bad_size: bus_error=%b m_cyc=%b expected 1 0", bus_error, m_cyc);
      end
      clear_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_priority_write();
      write_through_req = 1'b1; write_line_req = 1'b1; read_req = 1'b1;
      pa = 64'h3002; size = 4'b0001; wt_data = 64'h0000_0000_0000_005A;
      @(negedge clk);
      checks++;
      if (m_we !== 1'b1 || m_stb !== 1'b1 || m_sel !== 8'h04 || m_adr !== 64'h3000) begin
         errors++; $display("FAIL wt_bus: we=%b stb=%b sel=%h adr=%h expected 1 1 04 3000", m_we, m_stb, m_sel, m_adr);
      end
      checks++;
      if (m_dat_o !== 64'h5A5A5A5A_5A5A5A5A) begin
         errors++; $display("FAIL wt_data_rep: m_dat_o=%h expected 5a5a5a5a5a5a5a5a", m_dat_o);
      end
      m_ack = 1'b1;
      @(negedge clk);
      m_ack = 1'b0;
      checks++;
      if (trans_rdy !== 1'b1 || cache_entry_write !== 1'b0 || m_cyc !== 1'b0) begin
         errors++; $display("FAIL wt_done: trans_rdy=%b cew=%b m_cyc=%b expected 1 0 0", trans_rdy, cache_entry_write, m_cyc);
      end
      clear_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_read_line();
      int  beats  = 0;
      int  writes = 0;
      bit  done   = 0;
      pa = 64'h4038; read_line_req = 1'b1;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (line_write) begin
            checks++;
            if (addr_count !== 11'(writes * 8) || line_data !== rpat(64'h4000 + 64'(writes * 8))) begin
               errors++; $display("FAIL rl_write%0d: addr_count=%0d line_data=%h expected %0d %h",
                                  writes, addr_count, line_data, writes * 8, rpat(64'h4000 + 64'(writes * 8)));
            end
            writes++;
         end
         if (trans_rdy) begin
            done = 1;
            checks++;
            if (cache_entry_write !== 1'b1 || beats !== 8 || writes !== 8) begin
               errors++; $display("FAIL rl_done: cew=%b beats=%0d writes=%0d expected 1 8 8", cache_entry_write, beats, writes);
            end
            read_line_req = 1'b0;
         end
         if (m_stb) begin
            checks++;
            if (m_adr !== 64'h4000 + 64'(beats * 8) || m_sel !== 8'hFF || m_cyc !== 1'b1) begin
               errors++; $display("FAIL rl_beat%0d: adr=%h sel=%h cyc=%b expected %h ff 1",
                                  beats, m_adr, m_sel, m_cyc, 64'h4000 + 64'(beats * 8));
            end
            m_ack = 1'b1; m_dat_i = rpat(64'h4000 + 64'(beats * 8));
            beats++;
         end else begin
            m_ack = 1'b0;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL rl_timeout: trans_rdy never seen, beats=%0d writes=%0d expected 8 8", beats, writes);
      end
      clear_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_write_line();
      int          beats = 0;
      bit          prep  = 0;
      bit          done  = 0;
      logic [10:0] prep_off = '0;
      pa = 64'h8000; write_line_req = 1'b1;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge clk);
         if (trans_rdy) begin
            done = 1;
            checks++;
            if (beats !== 8 || cache_entry_write !== 1'b0 || m_cyc !== 1'b0) begin
               errors++; $display("FAIL wl_done: beats=%0d cew=%b m_cyc=%b expected 8 0 0", beats, cache_entry_write, m_cyc);
            end
            write_line_req = 1'b0;
         end
         if (m_stb) begin
            checks++;
            if (!prep || prep_off !== 11'(beats * 8) || m_adr !== 64'h8000 + 64'(beats * 8)
                || m_dat_o !== wpat(11'(beats * 8)) || m_we !== 1'b1) begin
               errors++; $display("FAIL wl_beat%0d: prep=%0d off=%0d adr=%h dat=%h we=%b expected 1 %0d %h %h 1",
                                  beats, prep, prep_off, m_adr, m_dat_o, m_we, beats * 8,
                                  64'h8000 + 64'(beats * 8), wpat(11'(beats * 8)));
            end
            prep  = 0;
            m_ack = 1'b1;
            beats++;
         end else begin
            m_ack = 1'b0;
            if (m_cyc) begin
               prep     = 1;
               prep_off = addr_count;
            end
         end
         wt_data = wpat(addr_count);
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL wl_timeout: trans_rdy never seen, beats=%0d expected 8", beats);
      end
      clear_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_read_line_error();
      int beats  = 0;
      int writes = 0;
      bit bad    = 0;
      bit done   = 0;
      pa = 64'h4000; read_line_req = 1'b1;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (line_write) writes++;
         if (trans_rdy || cache_entry_write) bad = 1;
         if (bus_error) begin
            done = 1;
            checks++;
            if (writes !== 3 || bad || m_cyc !== 1'b0 || m_stb !== 1'b0) begin
               errors++; $display("FAIL rl_err: writes=%0d bad_pulse=%0d cyc=%b stb=%b expected 3 0 0 0",
                                  writes, bad, m_cyc, m_stb);
            end
            read_line_req = 1'b0;
         end
         if (m_stb) begin
            if (beats == 3) m_err = 1'b1;
            else begin m_ack = 1'b1; m_dat_i = rpat(m_adr); end
            beats++;
         end else begin
            m_ack = 1'b0; m_err = 1'b0;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL rl_err_timeout: bus_error never seen, writes=%0d expected 3", writes);
      end
      @(negedge clk);
      checks++;
      if (trans_rdy !== 1'b0 || cache_entry_write !== 1'b0 || bus_error !== 1'b0 || beats !== 4) begin
         errors++; $display("FAIL rl_err_after: trans_rdy=%b cew=%b bus_error=%b beats=%0d expected 0 0 0 4",
                            trans_rdy, cache_entry_write, bus_error, beats);
      end
      clear_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_timeout();
      int start = -1;
      bit done  = 0;
      read_req = 1'b1; pa = 64'h100; size = 4'b1000;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         if (m_stb && start < 0) start = cyc;
         if (bus_error) begin
            done = 1;
            checks++;
            if (cyc - start !== 255 || m_cyc !== 1'b0) begin
               errors++; $display("FAIL rd_timeout: bus_error after %0d cycles m_cyc=%b expected 255 0", cyc - start, m_cyc);
            end
            read_req = 1'b0;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL rd_timeout_missing: bus_error not seen within 400 cycles, expected after 255");
      end
      clear_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_async_reset();
      int beats = 0;
      pa = 64'h0; read_line_req = 1'b1;
      for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
         @(negedge clk);
         if (m_stb) begin
            m_ack = 1'b1; m_dat_i = rpat(m_adr);
            beats++;
         end
      end
      @(negedge clk);
      m_ack = 1'b0;
      checks++;
      if (m_cyc !== 1'b1 || m_stb !== 1'b1 || line_write !== 1'b1) begin
         errors++; $display("FAIL arst_pre: cyc=%b stb=%b line_write=%b expected 1 1 1", m_cyc, m_stb, line_write);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin
         errors++; $display("FAIL arst_bus: cyc=%b stb=%b expected 0 0", m_cyc, m_stb);
      end
      checks++;
      if (line_data !== 64'h0 || addr_count !== 11'h0 || line_write !== 1'b0 || m_adr !== 64'h0 || m_sel !== 8'h0) begin
         errors++; $display("FAIL arst_outs: line_data=%h addr_count=%0d lw=%b adr=%h sel=%h expected all 0",
                            line_data, addr_count, line_write, m_adr, m_sel);
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (m_cyc !== 1'b0 || trans_rdy !== 1'b0) begin
         errors++; $display("FAIL arst_after: cyc=%b trans_rdy=%b expected 0 0", m_cyc, trans_rdy);
      end
   endtask

   initial begin
      test_reset();
      test_read_single();
      test_misaligned();
      test_priority_write();
      test_read_line();
      test_write_line();
      test_read_line_error();
      test_timeout();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/l1_bus_unit.md
Name: l1_bus_unit

Overview:
- Cache bus unit directly downstream of the L1-I/L1-D request mux.
- Accepts one cache request at a time: write-through, write-line, single read or line read. Executes it as one or more beats on a Wishbone-B3-classic-style 64-bit master port.
- Returns beat data, beat offset, cache-write strobes and completion/error pulses to the mux.

Parameters:
- LINE_BYTES, 64, cache line size in bytes; power of two, 16..2048; beats = LINE_BYTES/8.
- TIMEOUT, 255, cycles to wait for m_ack/m_err per beat before declaring bus error; 0 disables.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- write_through_req  in  1  single write request
- write_line_req  in  1  full-line write-back request
- read_req  in  1  single read request
- read_line_req  in  1  full-line fill request
- size  in  4  one-hot byte count for single ops: 0001=1B, 0010=2B, 0100=4B, 1000=8B
- pa  in  64  physical address
- wt_data  in  64  write data; for line writes, line word at addr_count, valid one cycle after addr_count changes
- line_data  out  64  registered read data of current beat
- addr_count  out  11  byte offset within line of current beat (multiple of 8)
- line_write  out  1  pulse: line_data valid for offset addr_count, write to cache
- cache_entry_write  out  1  pulse: line fill complete, update tag/valid
- trans_rdy  out  1  pulse: request complete
- bus_error  out  1  pulse: request failed
- m_cyc, m_stb, m_we  out  1 each  bus cycle, strobe, write enable
- m_adr  out  64  bus byte address
- m_sel  out  8  byte lanes
- m_dat_o  out  64  bus write data
- m_dat_i  in  64  bus read data
- m_ack, m_err  in  1 each  beat acknowledge / beat error

Behaviour:
- Reset (async): state IDLE; all outputs 0, including addr_count and line_data; timeout counter 0. Mid-operation reset drops m_cyc/m_stb immediately; the cycle is abandoned.
- IDLE request priority: write_through_req > write_line_req > read_req > read_line_req. Request inputs are sampled only in IDLE.
- Requester holds its request and operands stable until trans_rdy or bus_error. It deasserts the request in the cycle after that pulse. IDLE ignores requests for one cycle after DONE/ERR so the mux can re-arbitrate.
- Single ops (WT, RD):
  - Alignment check: size must be one-hot, and pa must be aligned to size.
  - On violation go to ERR with no bus cycle.
  - Otherwise m_adr = {pa[63:3],3'b0}; m_sel = size-wide lane mask shifted by pa[2:0]; m_dat_o = wt_data replicated into lanes.
- Line ops (WL, RL):
  - Line base = pa with low log2(LINE_BYTES) bits cleared.
  - Beat k address = base + 8k; m_sel = 8'hFF.
  - Beats are issued in increasing order.
- States: IDLE, SGL, WL_PREP, WL_BEAT, RL_BEAT, DONE, ERR.
- SGL: m_cyc=m_stb=1 until m_ack/m_err.
  - RD: m_dat_i is registered into line_data on m_ack; DONE follows.
- WL_PREP: one cycle with addr_count=8k, letting the cache RAM present the word. At exit, wt_data is latched into m_dat_o and the block enters WL_BEAT.
- WL_BEAT: m_stb held until response.
  - On ack, the last beat goes to DONE.
  - Otherwise addr_count += 8 and the block returns to WL_PREP.
- RL_BEAT: on ack, m_dat_i is registered into line_data; addr_count = 8k; line_write pulses the next cycle.
  - Beat k+1 strobe may be issued in that same cycle; no idle required.
  - After the last beat's line_write, go to DONE.
- m_cyc stays high across all beats of a line op and drops on entering DONE/ERR.
- DONE: one cycle; trans_rdy=1. cache_entry_write=1 additionally for RL only.
- ERR: one cycle; bus_error=1. No trans_rdy or cache_entry_write. Line writes already issued for earlier beats are not retracted.
- m_err on any beat, or the timeout counter reaching TIMEOUT while m_stb is high with no response, causes ERR.
  - The counter resets on every new beat.
- m_ack and m_err in the same cycle: m_err wins.
- addr_count wraps modulo LINE_BYTES. For the LINE_BYTES=2048 maximum, the top offset is 2040.

Decomposition:
- Shared package l1_bus_pkg: state encoding, size one-hot constants, lane-mask function (size, pa[2:0] to sel), alignment-check function.
- Sub-module l1_bus_timeout: per-beat watchdog counter with clear/enable and expiry output.

Test Plan:
- read_req, pa=0x1004, size=0100, ack after 2 cycles with m_dat_i=0xAABBCCDD_11223344 -> m_adr=0x1000, m_sel=0xF0, line_data equals that value with trans_rdy=1 one cycle later.
- write_through_req, pa=0x2003, size=0010 -> no bus cycle; bus_error one pulse.
- read_line_req, pa=0x4038, LINE_BYTES=64, immediate acks -> 8 beats at 0x4000..0x4038; line_write 8 times with addr_count 0,8..56; then cache_entry_write and trans_rdy together.
- write_line_req at pa=0x8000 -> each beat preceded by WL_PREP; m_dat_o equals wt_data from cycle after addr_count set; 8 acks -> trans_rdy, no cache_entry_write.
- RL with m_err on beat 3 -> 3 line_write pulses, then bus_error, m_cyc low, no cache_entry_write.
- RD with no ack, TIMEOUT=255 -> bus_error 255 cycles after strobe.
- Async reset asserted mid-RL -> m_cyc/m_stb low same cycle; all outputs 0.
